compare_node: RTL and testbench

- Processing node for a 2-D grid of cells. Compares the node's own value `in` against its four neighbour values `in1`..`in4`.
- Asserts registered `out` when the node is a local maximum of its neighbourhood.
- Pure datapath: no handshake. Used as the per-cell element in a mesh of identical nodes.

---
 rtl/compare_node_pkg.sv | 11 +
 rtl/compare_node_if.sv | 18 +
 rtl/compare_node_mag_compare.sv | 16 +
 rtl/compare_node.sv | 57 +++++
 tb/tb_compare_node.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/compare_node_pkg.sv
// Shared constants for the grid compare node: default value width and
// comparison mode encodings.
package compare_node_pkg;

  localparam int unsigned DEFAULT_WIDTH = 2;

  // STRICT parameter encodings
  localparam bit MODE_GT = 1'b1;
  localparam bit MODE_GE = 1'b0;

endpackage : compare_node_pkg

// File: rtl/compare_node_if.sv
// Node value and neighbour values in, local-maximum flag out.
interface compare_node_if
  import compare_node_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] in3;
  logic [WIDTH-1:0] in4;
  logic             out;

  modport master (output in, in1, in2, in3, in4, input out);
  modport slave  (input in, in1, in2, in3, in4, output out);

endinterface : compare_node_if

// File: rtl/compare_node_mag_compare.sv
// Unsigned WIDTH-bit magnitude comparator: gt = (a > b), eq = (a == b).
module mag_compare
  import compare_node_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt,
  output logic             eq
);

  assign gt = (a > b);
  assign eq = (a == b);

endmodule : mag_compare

// File: rtl/compare_node.sv
// Grid node: registers its value and four neighbours, then flags a
// local maximum one cycle later (2-cycle latency, full throughput).
module compare_node
  import compare_node_pkg::*;
#(
  parameter int unsigned WIDTH  = DEFAULT_WIDTH,
  parameter bit          STRICT = MODE_GT
) (
  input logic           clk,
  input logic           rst,
  compare_node_if.slave bus
);

  localparam int unsigned NUM_NB = 4;

  logic [WIDTH-1:0]  in_q;
  logic [WIDTH-1:0]  nb_q [NUM_NB];
  logic [NUM_NB-1:0] gt_c;
  logic [NUM_NB-1:0] eq_c;
  logic [NUM_NB-1:0] pass_c;

  // One comparator per neighbour, all against the registered own value
  for (genvar i = 0; i < NUM_NB; i++) begin : g_cmp
    mag_compare #(.WIDTH(WIDTH)) u_cmp (
      .a  (in_q),
      .b  (nb_q[i]),
      .gt (gt_c[i]),
      .eq (eq_c[i])
    );
  end

  always_comb begin
    pass_c = '0;
    for (int i = 0; i < NUM_NB; i++) begin
      pass_c[i] = (STRICT == MODE_GT) ? gt_c[i] : (gt_c[i] | eq_c[i]);
    end
  end

  // Stage 1 captures the neighbourhood, stage 2 registers the AND of passes
  always_ff @(posedge clk) begin
    if (rst) begin
      in_q    <= '0;
      for (int i = 0; i < NUM_NB; i++) begin
        nb_q[i] <= '0;
      end
      bus.out <= 1'b0;
    end else begin
      in_q    <= bus.in;
      nb_q[0] <= bus.in1;
      nb_q[1] <= bus.in2;
      nb_q[2] <= bus.in3;
      nb_q[3] <= bus.in4;
      bus.out <= &pass_c;
    end
  end

endmodule : compare_node

// File: tb/tb_compare_node.sv
// Bench for compare_node: a strict and a non-strict instance driven with
// identical stimulus, checked through an expected-result queue.
module tb_compare_node;
  import compare_node_pkg::*;

  localparam int unsigned W = 2;

  logic clk;
  logic rst;

  compare_node_if #(.WIDTH(W)) bus_s ();
  compare_node_if #(.WIDTH(W)) bus_ns ();

  compare_node #(.WIDTH(W), .STRICT(MODE_GT)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (bus_s.slave)
  );

  compare_node #(.WIDTH(W), .STRICT(MODE_GE)) dut_ns (
    .clk (clk),
    .rst (rst),
    .bus (bus_ns.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic es;
    logic ens;
    logic ens_chk;
  } exp_t;

  typedef struct {
    logic [9:0] v;
    logic       es;
    logic       ens;
  } vec_t;

  exp_t exp_q [$];
  int   n_total;
  int   n_pass;

  task automatic chk(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  function automatic logic ref_out(input logic [9:0] v, input bit strict);
    logic [1:0] own;
    logic [1:0] nb;
    logic       r;
    own = v[9:8];
    r   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      nb = v[2*k +: 2];
      if (strict) r = r & (own > nb);
      else        r = r & (own >= nb);
    end
    return r;
  endfunction

  // Drive one input set for one edge, queue its expectation, check what is due
  task automatic step(input logic [9:0] v, input logic r,
                      input logic es, input logic ens, input logic ens_chk,
                      input string name);
    exp_t e;
    exp_t d;
    bit   have;
    @(negedge clk);
    rst       = r;
    bus_s.in  = v[9:8]; bus_ns.in  = v[9:8];
    bus_s.in1 = v[7:6]; bus_ns.in1 = v[7:6];
    bus_s.in2 = v[5:4]; bus_ns.in2 = v[5:4];
    bus_s.in3 = v[3:2]; bus_ns.in3 = v[3:2];
    bus_s.in4 = v[1:0]; bus_ns.in4 = v[1:0];
    // Reset zeroes stage 1: strict sees 0, non-strict reads 1 but is ignored
    if (r) begin e.es = 1'b0; e.ens = 1'b1; e.ens_chk = 1'b0; end
    else   begin e.es = es;   e.ens = ens;  e.ens_chk = ens_chk; end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    have = 1'b0;
    if (exp_q.size() == 2) begin
      d    = exp_q.pop_front();
      have = 1'b1;
    end
    if (r) begin
      chk({name, "_rst_s"},  bus_s.out,  1'b0);
      chk({name, "_rst_ns"}, bus_ns.out, 1'b0);
    end else if (have) begin
      chk({name, "_s"}, bus_s.out, d.es);
      if (d.ens_chk) chk({name, "_ns"}, bus_ns.out, d.ens);
    end
  endtask

  task automatic step_ref(input logic [9:0] v, input logic r, input string name);
    step(v, r, ref_out(v, 1'b1), ref_out(v, 1'b0), 1'b1, name);
  endtask

  vec_t vecs [12];

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst     = 1'b1;

    // {in, in1, in2, in3, in4}, strict expect, non-strict expect
    vecs[0]  = '{v: {2'd2, 2'd2, 2'd1, 2'd1, 2'd1}, es: 1'b0, ens: 1'b1};
    vecs[1]  = '{v: {2'd3, 2'd3, 2'd3, 2'd3, 2'd3}, es: 1'b0, ens: 1'b1};
    vecs[2]  = '{v: {2'd0, 2'd0, 2'd0, 2'd0, 2'd0}, es: 1'b0, ens: 1'b1};
    vecs[3]  = '{v: {2'd0, 2'd1, 2'd0, 2'd0, 2'd0}, es: 1'b0, ens: 1'b0};
    vecs[4]  = '{v: {2'd3, 2'd0, 2'd0, 2'd0, 2'd0}, es: 1'b1, ens: 1'b1};
    vecs[5]  = '{v: {2'd1, 2'd0, 2'd2, 2'd0, 2'd0}, es: 1'b0, ens: 1'b0};
    vecs[6]  = '{v: {2'd2, 2'd1, 2'd1, 2'd1, 2'd1}, es: 1'b1, ens: 1'b1};
    vecs[7]  = '{v: {2'd3, 2'd2, 2'd2, 2'd2, 2'd2}, es: 1'b1, ens: 1'b1};
    vecs[8]  = '{v: {2'd3, 2'd2, 2'd3, 2'd2, 2'd2}, es: 1'b0, ens: 1'b1};
    vecs[9]  = '{v: {2'd1, 2'd1, 2'd1, 2'd1, 2'd1}, es: 1'b0, ens: 1'b1};
    vecs[10] = '{v: {2'd2, 2'd0, 2'd3, 2'd0, 2'd0}, es: 1'b0, ens: 1'b0};
    vecs[11] = '{v: {2'd1, 2'd0, 2'd1, 2'd0, 2'd1}, es: 1'b0, ens: 1'b1};

    // Reset held three cycles with in=3, neighbours 0, then release
    for (int i = 0; i < 3; i++) step({2'd3, 8'd0}, 1'b1, 1'b0, 1'b0, 1'b0, "reset");
    step({2'd3, 8'd0}, 1'b0, 1'b1, 1'b1, 1'b1, "release");
    step({2'd3, 8'd0}, 1'b0, 1'b1, 1'b1, 1'b1, "release");

    // Table vectors back to back (entries 4,5,6 form the 1,0,1 sequence)
    for (int i = 0; i < 12; i++) begin
      step(vecs[i].v, 1'b0, vecs[i].es, vecs[i].ens, 1'b1, $sformatf("vec%0d", i));
    end

    // Mid-stream reset: 3/0, [rst] 1/in2=2, 2/1, 3/0, 1/in2=2
    step_ref({2'd3, 8'd0}, 1'b0, "mid");
    step_ref({2'd1, 2'd0, 2'd2, 4'd0}, 1'b1, "mid");
    step_ref({2'd2, 2'd1, 2'd1, 2'd1, 2'd1}, 1'b0, "mid");
    step_ref({2'd3, 8'd0}, 1'b0, "mid");
    step_ref({2'd1, 2'd0, 2'd2, 4'd0}, 1'b0, "mid");
    step_ref({2'd1, 2'd0, 2'd2, 4'd0}, 1'b0, "mid");

    // Exhaustive sweep, each value held four cycles
    for (int v = 0; v < 1024; v++) begin
      for (int h = 0; h < 4; h++) step_ref(10'(v), 1'b0, "sweep");
    end
    // Drain the last queued expectation
    step_ref(10'd0, 1'b0, "drain");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_compare_node
